multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle successor to the single-cycle instruction decoder: a state machine that sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables one state at a time. It extends the decoder in several ways: 4-bit ALU op with slt/sltu, unsigned branches, ready-handshaked instruction and data memory with a timeout watchdog, a sticky trap state and a retired-instruction counter. It sits between the IR/PC registers and the datapath muxes of the multi-cycle core.

## Interface
- TIMEOUT, 15: max wait cycles on imem_ready/dmem_ready before trap; 0 disables the watchdog.
- ENABLE_SLT, 1: 1 decodes slt/sltu/slti/sltiu; 0 makes them illegal.
- CNT_W, 32: instret counter width.
- clk  in  1  clock; everything updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- inst  in  32  IR contents; sampled only in DECODE.
- br_true  in  1  branch comparator result for the current br_ctrl; sampled in EXEC.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- ir_we  out  1  load IR.
- pc_we  out  1  update PC; asserted exactly once per retired instruction.
- npc_op  out  2  next-PC select: 0 = pc+4, 1 = pc+imm, 2 = alu result with bit0 cleared.
- br_ctrl  out  3  branch compare: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu.
- sext_op  out  3  immediate format: 0 I, 1 B, 2 J, 3 S, 4 U.
- alu_op  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- alub_sel  out  2  ALU B operand: 0 rs2, 1 imm.
- wd_sel  out  2  register write data: 0 alu, 1 pc+4, 2 imm, 3 dram.
- rf_we  out  1  register file write.
- dram_re  out  1  data read request.
- dram_we  out  1  data write request.
- retire  out  1  single-cycle pulse; coincides with pc_we.
- instret  out  CNT_W  count of retired instructions.
- trap  out  1  sticky; high while in TRAP.
- trap_cause  out  2  trap reason: 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout.
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP.

## Operation
- Decoded fields (class, alu_op, sext_op, br_ctrl, wd_sel, alub_sel, npc_op) are latched into an internal register at the end of DECODE.
- Outputs are combinational from the current state and the latched decode. Enables are 0 in any state that does not name them.
- FETCH: ir_we = imem_ready. On imem_ready, go to DECODE; otherwise stay in FETCH.
- DECODE: if the instruction is illegal, go to TRAP with cause 1; otherwise go to EXEC.
  - Legal set: R-type (funct7 = 0, or 0x20 for sub/sra), I-ALU (shifts need imm[11:5] = 0 or 0x20 for srai), lw/sw (funct3 = 010), branches (funct3 ≠ 010/011), lui, jal, jalr (funct3 = 000).
  - slt/sltu/slti/sltiu are legal only when ENABLE_SLT = 1.
- EXEC:
  - Branch: pc_we = 1, npc_op = br_true ? 1 : 0, retire; go to FETCH.
  - lw/sw: alu_op = add, alub_sel = 1; go to MEM.
  - All other instructions: go to WB.
- MEM: hold dram_re (lw) or dram_we (sw) high until dmem_ready.
  - On dmem_ready, sw does pc_we = 1, npc_op = 0, retire, and goes to FETCH.
  - On dmem_ready, lw goes to WB.
- WB: rf_we = 1, pc_we = 1, retire; go to FETCH.
  - npc_op: jal 1, jalr 2, others 0.
  - wd_sel: jal/jalr 1, lui 2, lw 3, others 0.
- Watchdog: wait_cnt clears on every state entry and increments each cycle spent in FETCH with imem_ready = 0 or in MEM with dmem_ready = 0.
  - If wait_cnt reaches TIMEOUT, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - A ready arriving in the same cycle as the limit wins; no trap.
- TRAP: all enables are 0 and state stays in TRAP until reset.
- instret increments when retire = 1 and wraps modulo 2^CNT_W.

## Timing
- Reset: state = FETCH, all enables 0, trap = 0, trap_cause = 0, instret = 0, wait_cnt = 0, latched decode = 0.
- Reset asserted mid-instruction aborts it: no pc_we, rf_we or dram_we in the reset cycle.
- Latency with zero-wait memory: branch 3 cycles; R/I/lui/jal/jalr 4; sw 4; lw 5.
- Each cycle of ready low adds one cycle to FETCH or MEM.
- dram_re/dram_we stay stable while dmem_ready is low and drop in the cycle after dmem_ready.
- inst changes outside DECODE have no effect.

## Test plan
- Reset, zero-wait memory, `add x1,x2,x3`:
  - state goes 0,1,2,4,0.
  - WB cycle shows rf_we = 1, pc_we = 1, alu_op = 0, wd_sel = 0, retire = 1.
  - instret = 1 afterwards.
- Zero-wait memory, `lw`, then `sw`:
  - lw: states 0,1,2,3,4; dram_re high in MEM only; wd_sel = 3 in WB.
  - sw: states 0,1,2,3,0; dram_we high in MEM; pc_we in MEM; rf_we never high.
- Zero-wait memory, `bltu` with br_true = 1, then `bgeu` with br_true = 0:
  - bltu: br_ctrl = 5; pc_we in EXEC; npc_op = 1.
  - bgeu: br_ctrl = 6; npc_op = 0.
  - Each takes 3 cycles.
- Data-memory timeout boundary:
  - dmem_ready low for 14 cycles in MEM, then high with TIMEOUT = 15: completes normally.
  - dmem_ready held low: reaches TRAP, trap_cause = 3, no retire.
  - TRAP is held until rst_n = 0.
- Illegal-encoding checks:
  - Opcode 0x7F → TRAP, cause 1, no pc_we.
  - slti with ENABLE_SLT = 0 → trap.
  - slti with ENABLE_SLT = 1 → alu_op = 8.
- Reset during MEM with dram_we high: that cycle has dram_we = 0; state = FETCH and instret = 0 after reset.

Source files
------------

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: FSM that walks each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath enables, with memory-wait watchdog, sticky trap and retire counter.
module multi_cycle_control #(
    parameter int TIMEOUT    = 15,
    parameter int ENABLE_SLT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_inst,
    input  logic             i_br_true,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic [1:0]       o_npc_op,
    output logic [2:0]       o_br_ctrl,
    output logic [2:0]       o_sext_op,
    output logic [3:0]       o_alu_op,
    output logic [1:0]       o_alub_sel,
    output logic [1:0]       o_wd_sel,
    output logic             o_rf_we,
    output logic             o_dram_re,
    output logic             o_dram_we,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instret,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [2:0]       o_state
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [1:0] {C_OTHER, C_BR, C_LW, C_SW} cls_t;
    typedef struct packed {
        cls_t       cls;
        logic [3:0] alu;
        logic [2:0] sext;
        logic [2:0] br;
        logic [1:0] wd;
        logic [1:0] alub;
        logic [1:0] npc;
    } dec_t;
    localparam int WW = $clog2(TIMEOUT + 1) + 1;

    state_t           r_state, w_next;
    dec_t             r_dec, w_dec;
    logic [WW-1:0]    r_wait;
    logic [1:0]       r_cause, w_cause;
    logic [CNT_W-1:0] r_instret;
    logic [6:0]       w_op, w_f7;
    logic [2:0]       w_f3;
    logic [3:0]       w_alu;
    logic             w_alt, w_slt_bad, w_illegal, w_limit, w_br_ex, w_sw_done, w_unused;

    assign w_op      = i_inst[6:0];
    assign w_f3      = i_inst[14:12];
    assign w_f7      = i_inst[31:25];
    assign w_unused  = ^{i_inst[24:15], i_inst[11:7]};
    assign w_alt     = i_inst[30] && (w_f3 == 3'd5 || (w_f3 == 3'd0 && w_op == 7'h33));
    assign w_slt_bad = ENABLE_SLT == 0 && (w_f3 == 3'd2 || w_f3 == 3'd3);
    assign w_limit   = TIMEOUT != 0 && r_wait == WW'(TIMEOUT - 1);
    assign w_br_ex   = r_state == EXEC && r_dec.cls == C_BR;
    assign w_sw_done = r_state == MEM && r_dec.cls == C_SW && i_dmem_ready;

    always_comb begin
        case (w_f3)
            3'd0: w_alu = w_alt ? 4'd1 : 4'd0;
            3'd1: w_alu = 4'd5;
            3'd2: w_alu = 4'd8;
            3'd3: w_alu = 4'd9;
            3'd4: w_alu = 4'd4;
            3'd5: w_alu = w_alt ? 4'd7 : 4'd6;
            3'd6: w_alu = 4'd3;
            default: w_alu = 4'd2;
        endcase
    end

    always_comb begin
        w_dec     = '0;
        w_illegal = 1'b0;
        case (w_op)
            7'h33: begin
                w_dec.alu = w_alu;
                w_illegal = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) || w_slt_bad;
            end
            7'h13: begin
                w_dec.alu  = w_alu;
                w_dec.alub = 2'd1;
                w_illegal  = (w_f3 == 3'd1 && w_f7 != 7'h00) ||
                             (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20) || w_slt_bad;
            end
            7'h03: begin
                w_dec.cls  = C_LW;
                w_dec.alub = 2'd1;
                w_dec.wd   = 2'd3;
                w_illegal  = w_f3 != 3'd2;
            end
            7'h23: begin
                w_dec.cls  = C_SW;
                w_dec.sext = 3'd3;
                w_dec.alub = 2'd1;
                w_illegal  = w_f3 != 3'd2;
            end
            7'h63: begin
                // funct3 {0,1,4,5,6,7} maps onto compare codes 1..6
                w_dec.cls  = C_BR;
                w_dec.sext = 3'd1;
                w_dec.br   = w_f3[2] ? w_f3 - 3'd1 : w_f3 + 3'd1;
                w_illegal  = w_f3 == 3'd2 || w_f3 == 3'd3;
            end
            7'h37: begin
                w_dec.sext = 3'd4;
                w_dec.wd   = 2'd2;
            end
            7'h6F: begin
                w_dec.sext = 3'd2;
                w_dec.wd   = 2'd1;
                w_dec.npc  = 2'd1;
            end
            7'h67: begin
                w_dec.alub = 2'd1;
                w_dec.wd   = 2'd1;
                w_dec.npc  = 2'd2;
                w_illegal  = w_f3 != 3'd0;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:  w_next = i_imem_ready ? DECODE : (w_limit ? TRAP : FETCH);
            DECODE: w_next = w_illegal ? TRAP : EXEC;
            EXEC:   w_next = r_dec.cls == C_BR ? FETCH : (r_dec.cls == C_OTHER ? WB : MEM);
            MEM:    w_next = !i_dmem_ready ? (w_limit ? TRAP : MEM) : (r_dec.cls == C_LW ? WB : FETCH);
            WB:     w_next = FETCH;
            default: w_next = TRAP;
        endcase
        w_cause      = (w_next == TRAP && r_state != TRAP) ?
                       (r_state == DECODE ? 2'd1 : (r_state == FETCH ? 2'd2 : 2'd3)) : r_cause;
        // enables are gated by reset so an aborted instruction commits nothing
        o_ir_we      = i_rst_n && r_state == FETCH && i_imem_ready;
        o_retire     = i_rst_n && (w_br_ex || w_sw_done || r_state == WB);
        o_pc_we      = o_retire;
        o_rf_we      = i_rst_n && r_state == WB;
        o_dram_re    = i_rst_n && r_state == MEM && r_dec.cls == C_LW;
        o_dram_we    = i_rst_n && r_state == MEM && r_dec.cls == C_SW;
        o_npc_op     = r_state == WB ? r_dec.npc : ((w_br_ex && i_br_true) ? 2'd1 : 2'd0);
        o_br_ctrl    = r_dec.br;
        o_sext_op    = r_dec.sext;
        o_alu_op     = r_dec.alu;
        o_alub_sel   = r_dec.alub;
        o_wd_sel     = r_dec.wd;
        o_trap       = r_state == TRAP;
        o_trap_cause = r_cause;
        o_state      = r_state;
        o_instret    = r_instret;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= FETCH;
            r_dec     <= '0;
            r_wait    <= '0;
            r_cause   <= '0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_cause   <= w_cause;
            r_wait    <= (w_next == r_state && r_state != TRAP) ? r_wait + 1'b1 : '0;
            r_dec     <= r_state == DECODE ? w_dec : r_dec;
            r_instret <= o_retire ? r_instret + 1'b1 : r_instret;
        end
    end
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: randomized bench; expected traces come from a per-instruction model.
module tb_multi_cycle_control;
    localparam int K_REG = 0, K_BR = 1, K_LW = 2, K_SW = 3;
    typedef struct {
        string nm;
        int    opc, f3, f7, kind, alu, sext, br, wd, alub, npc, slt;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, br_true = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [31:0] inst = '0;
    logic        ir_we[3], pc_we[3], rf_we[3], dram_re[3], dram_we[3], retire[3], trap[3];
    logic [1:0]  npc_op[3], alub_sel[3], wd_sel[3], trap_cause[3];
    logic [2:0]  br_ctrl[3], sext_op[3], state[3];
    logic [3:0]  alu_op[3];
    logic [31:0] instret[3];

    int          tmo[3]    = '{15, 15, 0};
    bit          slt_ok[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mask[3]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
    op_t         ops[$];
    op_t         nop_e;
    int unsigned n_ret = 0;
    bit          m_trap = 1'b0;
    logic [1:0]  m_cause = 2'd0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 4 : 32;
        logic [CW-1:0] cnt;
        multi_cycle_control #(.TIMEOUT(g == 2 ? 0 : 15), .ENABLE_SLT(g == 1 ? 0 : 1), .CNT_W(CW)) dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_br_true(br_true),
            .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
            .o_ir_we(ir_we[g]), .o_pc_we(pc_we[g]), .o_npc_op(npc_op[g]), .o_br_ctrl(br_ctrl[g]),
            .o_sext_op(sext_op[g]), .o_alu_op(alu_op[g]), .o_alub_sel(alub_sel[g]), .o_wd_sel(wd_sel[g]),
            .o_rf_we(rf_we[g]), .o_dram_re(dram_re[g]), .o_dram_we(dram_we[g]), .o_retire(retire[g]),
            .o_instret(cnt), .o_trap(trap[g]), .o_trap_cause(trap_cause[g]), .o_state(state[g])
        );
        assign instret[g] = 32'(cnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic def(input string nm, input int opc, f3, f7, kind, alu, sext, br, wd, alub, npc, slt);
        op_t o;
        o.nm = nm; o.opc = opc; o.f3 = f3; o.f7 = f7; o.kind = kind; o.alu = alu;
        o.sext = sext; o.br = br; o.wd = wd; o.alub = alub; o.npc = npc; o.slt = slt;
        ops.push_back(o);
    endtask

    function automatic op_t find(input string nm);
        foreach (ops[i]) if (ops[i].nm == nm) return ops[i];
        return nop_e;
    endfunction

    function automatic logic [31:0] enc(input op_t e);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = 7'(e.opc);
        if (e.f3 >= 0) w[14:12] = 3'(e.f3);
        if (e.f7 >= 0) w[31:25] = 7'(e.f7);
        return w;
    endfunction

    function automatic logic [31:0] bad();
        logic [31:0] w;
        logic [2:0]  f;
        logic [6:0]  o;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: begin w[6:0] = 7'h33; w[31:25] = 7'($urandom_range(1, 31)); end
            1: begin
                do f = 3'($urandom); while (f == 3'd0 || f == 3'd5);
                w[6:0] = 7'h33; w[31:25] = 7'h20; w[14:12] = f;
            end
            2: begin
                do f = 3'($urandom); while (f == 3'd2);
                w[6:0] = $urandom_range(0, 1) ? 7'h23 : 7'h03; w[14:12] = f;
            end
            3: begin w[6:0] = 7'h63; w[14:12] = {2'b01, 1'($urandom)}; end
            4: begin w[6:0] = 7'h67; w[14:12] = 3'($urandom_range(1, 7)); end
            5: begin
                w[6:0] = 7'h13; w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
                w[31:25] = 7'($urandom_range(1, 31));
            end
            default: begin
                do o = 7'($urandom);
                while (o inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F});
                w[6:0] = o;
            end
        endcase
        return w;
    endfunction

    task automatic rnd_in();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        br_true    = 1'($urandom);
        inst       = $urandom;
    endtask

    task automatic observe(input int sel, input string ph, input logic [2:0] st, input logic [5:0] en,
                           input logic [1:0] npc, input bit df, input op_t e);
        @(negedge clk);
        check({ph, ".state"}, 32'(state[sel]), 32'(st));
        check({ph, ".en"}, 32'({ir_we[sel], pc_we[sel], rf_we[sel], dram_re[sel], dram_we[sel], retire[sel]}), 32'(en));
        check({ph, ".npc"}, 32'(npc_op[sel]), 32'(npc));
        check({ph, ".trap"}, 32'({trap[sel], trap_cause[sel]}), 32'({m_trap, m_cause}));
        check({ph, ".instret"}, instret[sel], n_ret & mask[sel]);
        if (df) begin
            check({ph, ".alu"}, 32'(alu_op[sel]), e.alu);
            check({ph, ".sext"}, 32'(sext_op[sel]), e.sext);
            check({ph, ".br"}, 32'(br_ctrl[sel]), e.br);
            check({ph, ".wd"}, 32'(wd_sel[sel]), e.wd);
            check({ph, ".alub"}, 32'(alub_sel[sel]), e.alub);
        end
        @(posedge clk);
        #1;
        if (en[0]) n_ret++;
    endtask

    task automatic do_reset(input int sel);
        rnd_in();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset.en", 32'({ir_we[sel], pc_we[sel], rf_we[sel], dram_re[sel], dram_we[sel], retire[sel]}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_ret = 0;
        m_trap = 1'b0;
        m_cause = 2'd0;
    endtask

    task automatic trap_now(input int sel, input logic [1:0] c);
        m_trap = 1'b1;
        m_cause = c;
        repeat (3) begin
            rnd_in();
            observe(sel, "trap", 3'd5, 6'd0, 2'd0, 0, nop_e);
        end
        do_reset(sel);
    endtask

    // one instruction: nf/nm = ready-low cycles in FETCH/MEM, abort = MEM cycle that sees reset
    task automatic run(input int sel, input logic [31:0] ins, input bit ill, input op_t e,
                       input int nf, input int nm, input bit bt, input int abort);
        for (int k = 0; k <= nf; k++) begin
            rnd_in();
            imem_ready = (k == nf);
            observe(sel, "fetch", 3'd0, {imem_ready, 5'b0}, 2'd0, 0, e);
            if (k < nf && tmo[sel] != 0 && k == tmo[sel] - 1) begin
                trap_now(sel, 2'd2);
                return;
            end
        end
        rnd_in();
        inst = ins;
        observe(sel, "decode", 3'd1, 6'd0, 2'd0, 0, e);
        if (ill) begin
            trap_now(sel, 2'd1);
            return;
        end
        rnd_in();
        br_true = bt;
        if (e.kind == K_BR) begin
            observe(sel, {e.nm, ".exec"}, 3'd2, 6'b010001, {1'b0, bt}, 1, e);
            return;
        end
        observe(sel, {e.nm, ".exec"}, 3'd2, 6'd0, 2'd0, 1, e);
        if (e.kind == K_LW || e.kind == K_SW) begin
            for (int k = 0; k <= nm; k++) begin
                rnd_in();
                dmem_ready = (k == nm);
                if (k == abort) begin
                    rst_n = 1'b0;
                    observe(sel, "abort", 3'd3, 6'd0, 2'd0, 0, e);
                    rst_n = 1'b1;
                    n_ret = 0;
                    m_trap = 1'b0;
                    m_cause = 2'd0;
                    return;
                end
                observe(sel, {e.nm, ".mem"}, 3'd3,
                        e.kind == K_LW ? 6'b000100 : {1'b0, dmem_ready, 2'b00, 1'b1, dmem_ready}, 2'd0, 1, e);
                if (k < nm && tmo[sel] != 0 && k == tmo[sel] - 1) begin
                    trap_now(sel, 2'd3);
                    return;
                end
            end
            if (e.kind == K_SW) return;
        end
        rnd_in();
        observe(sel, {e.nm, ".wb"}, 3'd4, 6'b011001, 2'(e.npc), 1, e);
    endtask

    task automatic rand_run(input int sel);
        op_t         e;
        bit          ill;
        logic [31:0] w;
        int          nf, nm;
        nf = $urandom_range(0, 9) == 0 ? $urandom_range(10, 18) : $urandom_range(0, 2);
        nm = $urandom_range(0, 9) == 0 ? $urandom_range(10, 18) : $urandom_range(0, 2);
        if ($urandom_range(0, 5) == 0) begin
            e = nop_e; ill = 1'b1; w = bad();
        end else begin
            e = ops[$urandom_range(0, ops.size() - 1)];
            ill = e.slt != 0 && !slt_ok[sel];
            w = enc(e);
        end
        run(sel, w, ill, e, nf, nm, 1'($urandom), -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nop_e.nm = "illegal";
        def("add", 'h33, 0, 0, K_REG, 0, 0, 0, 0, 0, 0, 0);
        def("sub", 'h33, 0, 'h20, K_REG, 1, 0, 0, 0, 0, 0, 0);
        def("sll", 'h33, 1, 0, K_REG, 5, 0, 0, 0, 0, 0, 0);
        def("slt", 'h33, 2, 0, K_REG, 8, 0, 0, 0, 0, 0, 1);
        def("sltu", 'h33, 3, 0, K_REG, 9, 0, 0, 0, 0, 0, 1);
        def("xor", 'h33, 4, 0, K_REG, 4, 0, 0, 0, 0, 0, 0);
        def("srl", 'h33, 5, 0, K_REG, 6, 0, 0, 0, 0, 0, 0);
        def("sra", 'h33, 5, 'h20, K_REG, 7, 0, 0, 0, 0, 0, 0);
        def("or", 'h33, 6, 0, K_REG, 3, 0, 0, 0, 0, 0, 0);
        def("and", 'h33, 7, 0, K_REG, 2, 0, 0, 0, 0, 0, 0);
        def("addi", 'h13, 0, -1, K_REG, 0, 0, 0, 0, 1, 0, 0);
        def("slti", 'h13, 2, -1, K_REG, 8, 0, 0, 0, 1, 0, 1);
        def("sltiu", 'h13, 3, -1, K_REG, 9, 0, 0, 0, 1, 0, 1);
        def("xori", 'h13, 4, -1, K_REG, 4, 0, 0, 0, 1, 0, 0);
        def("ori", 'h13, 6, -1, K_REG, 3, 0, 0, 0, 1, 0, 0);
        def("andi", 'h13, 7, -1, K_REG, 2, 0, 0, 0, 1, 0, 0);
        def("slli", 'h13, 1, 0, K_REG, 5, 0, 0, 0, 1, 0, 0);
        def("srli", 'h13, 5, 0, K_REG, 6, 0, 0, 0, 1, 0, 0);
        def("srai", 'h13, 5, 'h20, K_REG, 7, 0, 0, 0, 1, 0, 0);
        def("lw", 'h03, 2, -1, K_LW, 0, 0, 0, 3, 1, 0, 0);
        def("sw", 'h23, 2, -1, K_SW, 0, 3, 0, 0, 1, 0, 0);
        def("beq", 'h63, 0, -1, K_BR, 0, 1, 1, 0, 0, 0, 0);
        def("bne", 'h63, 1, -1, K_BR, 0, 1, 2, 0, 0, 0, 0);
        def("blt", 'h63, 4, -1, K_BR, 0, 1, 3, 0, 0, 0, 0);
        def("bge", 'h63, 5, -1, K_BR, 0, 1, 4, 0, 0, 0, 0);
        def("bltu", 'h63, 6, -1, K_BR, 0, 1, 5, 0, 0, 0, 0);
        def("bgeu", 'h63, 7, -1, K_BR, 0, 1, 6, 0, 0, 0, 0);
        def("lui", 'h37, -1, -1, K_REG, 0, 4, 0, 2, 0, 0, 0);
        def("jal", 'h6F, -1, -1, K_REG, 0, 2, 0, 1, 0, 1, 0);
        def("jalr", 'h67, 0, -1, K_REG, 0, 0, 0, 1, 1, 2, 0);

        do_reset(0);
        run(0, 32'h003100B3, 0, find("add"), 0, 0, 0, -1);
        run(0, enc(find("lw")), 0, find("lw"), 0, 0, 0, -1);
        run(0, enc(find("sw")), 0, find("sw"), 0, 0, 0, -1);
        run(0, enc(find("bltu")), 0, find("bltu"), 0, 0, 1, -1);
        run(0, enc(find("bgeu")), 0, find("bgeu"), 0, 0, 0, -1);
        run(0, enc(find("lw")), 0, find("lw"), 0, 14, 0, -1);
        run(0, enc(find("sw")), 0, find("sw"), 0, 40, 0, -1);
        run(0, 32'h0000_007F, 1, nop_e, 0, 0, 0, -1);
        run(0, enc(find("slti")), 0, find("slti"), 0, 0, 0, -1);
        run(0, enc(find("add")), 0, find("add"), 2, 0, 0, -1);
        run(0, enc(find("sw")), 0, find("sw"), 0, 3, 0, 1);
        repeat (60) rand_run(0);

        do_reset(1);
        run(1, enc(find("slti")), 1, find("slti"), 0, 0, 0, -1);
        repeat (40) rand_run(1);

        do_reset(2);
        run(2, enc(find("lw")), 0, find("lw"), 20, 20, 0, -1);
        repeat (40) rand_run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
